invader_formation: RTL and testbench

Parametrised invader-grid controller, successor to the fixed 5×11 invaders logic. It holds the alive mask and the formation origin, and marches the grid on an internal frame-counted tick. It steps down and reverses at screen edges, using the extents of the live columns. With the speed-up option it shortens the march interval as invaders die, and it flags wave-clear and bottom-reached. Working state is double-buffered: the renderer and the collision logic see only values published at `frame`.

---
 rtl/invader_formation_if.sv | 32 +++
 rtl/invader_formation.sv | 195 +++++++++++++++++++
 tb/tb_invader_formation.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/invader_formation_if.sv
// Invader formation bus: frame/restart/hit strobes toward the controller,
// frame-published grid state and event pulses back from it.
interface invader_formation_if #(
    parameter int unsigned ROWS = 5,
    parameter int unsigned COLS = 11
);
    localparam int unsigned N  = ROWS * COLS;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = $clog2(N + 1);

    logic          frame;
    logic          done;
    logic          hit_valid;
    logic [IW-1:0] hit_idx;
    logic [N-1:0]  alive;
    logic [9:0]    form_x;
    logic [9:0]    form_y;
    logic [CW-1:0] alive_count;
    logic          move_pulse;
    logic          wave_clear;
    logic          reached_bottom;

    modport master (
        output frame, done, hit_valid, hit_idx,
        input  alive, form_x, form_y, alive_count, move_pulse, wave_clear, reached_bottom
    );

    modport slave (
        input  frame, done, hit_valid, hit_idx,
        output alive, form_x, form_y, alive_count, move_pulse, wave_clear, reached_bottom
    );
endinterface

// File: rtl/invader_formation.sv
// Invader grid controller: alive mask, marching origin, edge/bottom detection, frame-published state.
// Optional INVADER_SPEEDUP_EN: march interval shrinks as the live count drops.
module invader_formation #(
    parameter int unsigned ROWS          = 5,
    parameter int unsigned COLS          = 11,
    parameter int unsigned CELL_W        = 32,
    parameter int unsigned CELL_H        = 32,
    parameter int unsigned RES_H         = 640,
    parameter int unsigned BOTTOM_Y      = 416,
    parameter int unsigned START_X       = 64,
    parameter int unsigned START_Y       = 48,
    parameter int unsigned STEP_X        = 4,
    parameter int unsigned STEP_Y        = 16,
    parameter int unsigned BASE_INTERVAL = 32,
    parameter int unsigned MIN_INTERVAL  = 2,
    parameter int unsigned SPEED_SHIFT   = 1
) (
    input  logic               clk,
    input  logic               rst,
    invader_formation_if.slave bus
);
    localparam int unsigned N         = ROWS * COLS;
    localparam int unsigned CW        = $clog2(N + 1);
    localparam int unsigned CIW       = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned RIW       = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned PW        = 10;
    localparam int unsigned EW        = 12;
    localparam int unsigned SPEED_MAX = MIN_INTERVAL + (N >> SPEED_SHIFT);
    localparam int unsigned IMAX      = (BASE_INTERVAL > SPEED_MAX) ? BASE_INTERVAL : SPEED_MAX;
    localparam int unsigned CNTW      = $clog2(IMAX + 1);

    logic [N-1:0]    mask_q, mask_d;
    logic [PW-1:0]   x_q, x_d, y_q, y_d;
    logic            dir_q, dir_d;
    logic [CNTW-1:0] cnt_q, cnt_d, cnt_inc, interval;
    logic [CW-1:0]   live_q, live_d;
    logic            halted_q, halted_d;
    logic            move_d, clear_d, bottom_d;
    logic            hit_ok;
    logic [CIW-1:0]  l_col, r_col;
    logic [RIW-1:0]  b_row;
    logic            right_edge, left_edge, at_bottom;

`ifdef INVADER_SPEEDUP_EN
    logic [CNTW-1:0] interval_q, interval_d;
    assign interval = interval_q;
`else
    assign interval = CNTW'(BASE_INTERVAL);
`endif

    // Row/column occupancy of the registered mask
    logic [ROWS-1:0] col_bits [COLS];
    logic [COLS-1:0] col_any;
    logic [ROWS-1:0] row_any;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        assign row_any[r] = |mask_q[r*COLS +: COLS];
        for (genvar c = 0; c < COLS; c++) begin : g_cell
            assign col_bits[c][r] = mask_q[r*COLS + c];
        end
    end
    for (genvar c = 0; c < COLS; c++) begin : g_col
        assign col_any[c] = |col_bits[c];
    end

    always_comb begin
        l_col = '0;
        r_col = '0;
        b_row = '0;
        for (int c = COLS - 1; c >= 0; c--) if (col_any[CIW'(c)]) l_col = CIW'(c);
        for (int c = 0; c < COLS; c++)      if (col_any[CIW'(c)]) r_col = CIW'(c);
        for (int r = 0; r < ROWS; r++)      if (row_any[RIW'(r)]) b_row = RIW'(r);
    end

    // Edge tests widened so the sums cannot wrap
    assign right_edge = (EW'(x_q) + (EW'(r_col) + EW'(1)) * EW'(CELL_W) + EW'(STEP_X)) > EW'(RES_H);
    assign left_edge  = (EW'(x_q) + EW'(l_col) * EW'(CELL_W)) < EW'(STEP_X);
    assign at_bottom  = (EW'(y_q) + (EW'(b_row) + EW'(1)) * EW'(CELL_H)) >= EW'(BOTTOM_Y);

    assign hit_ok  = bus.hit_valid && (32'(bus.hit_idx) < N) && mask_q[bus.hit_idx];
    assign cnt_inc = cnt_q + CNTW'(1);

    always_comb begin
        mask_d   = mask_q;
        x_d      = x_q;
        y_d      = y_q;
        dir_d    = dir_q;
        cnt_d    = cnt_q;
        live_d   = live_q;
        halted_d = halted_q;
        move_d   = 1'b0;
        clear_d  = 1'b0;
        bottom_d = bus.reached_bottom;
`ifdef INVADER_SPEEDUP_EN
        interval_d = interval_q;
`endif
        if (hit_ok) begin
            mask_d = mask_q & ~(N'(1) << bus.hit_idx);
            live_d = live_q - CW'(1);
            if (live_q == CW'(1)) begin
                clear_d  = 1'b1;
                halted_d = 1'b1;
            end
        end
        // March decisions use the registered mask, not this cycle's hit
        if (bus.frame && !halted_q) begin
            if (cnt_inc >= interval) begin
                cnt_d  = '0;
                move_d = 1'b1;
`ifdef INVADER_SPEEDUP_EN
                interval_d = CNTW'(MIN_INTERVAL) + CNTW'(live_q >> SPEED_SHIFT);
`endif
                if (dir_q) begin
                    if (right_edge) begin
                        y_d   = y_q + PW'(STEP_Y);
                        dir_d = 1'b0;
                    end else begin
                        x_d = x_q + PW'(STEP_X);
                    end
                end else begin
                    if (left_edge) begin
                        y_d   = y_q + PW'(STEP_Y);
                        dir_d = 1'b1;
                    end else begin
                        x_d = x_q - PW'(STEP_X);
                    end
                end
            end else begin
                cnt_d = cnt_inc;
            end
        end
        if ((live_q != '0) && at_bottom) begin
            bottom_d = 1'b1;
            halted_d = 1'b1;
        end
        if (bus.done) begin
            mask_d   = '1;
            x_d      = PW'(START_X);
            y_d      = PW'(START_Y);
            dir_d    = 1'b1;
            cnt_d    = '0;
            live_d   = CW'(N);
            halted_d = 1'b0;
            move_d   = 1'b0;
            clear_d  = 1'b0;
            bottom_d = 1'b0;
`ifdef INVADER_SPEEDUP_EN
            interval_d = CNTW'(SPEED_MAX);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q             <= '1;
            x_q                <= PW'(START_X);
            y_q                <= PW'(START_Y);
            dir_q              <= 1'b1;
            cnt_q              <= '0;
            live_q             <= CW'(N);
            halted_q           <= 1'b0;
`ifdef INVADER_SPEEDUP_EN
            interval_q         <= CNTW'(SPEED_MAX);
`endif
            bus.alive          <= '1;
            bus.form_x         <= PW'(START_X);
            bus.form_y         <= PW'(START_Y);
            bus.alive_count    <= CW'(N);
            bus.move_pulse     <= 1'b0;
            bus.wave_clear     <= 1'b0;
            bus.reached_bottom <= 1'b0;
        end else begin
            mask_q             <= mask_d;
            x_q                <= x_d;
            y_q                <= y_d;
            dir_q              <= dir_d;
            cnt_q              <= cnt_d;
            live_q             <= live_d;
            halted_q           <= halted_d;
`ifdef INVADER_SPEEDUP_EN
            interval_q         <= interval_d;
`endif
            bus.move_pulse     <= move_d;
            bus.wave_clear     <= clear_d;
            bus.reached_bottom <= bottom_d;
            // Publish pre-update working state; a restart holds the old picture
            if (bus.frame && !bus.done) begin
                bus.alive       <= mask_q;
                bus.form_x      <= x_q;
                bus.form_y      <= y_q;
                bus.alive_count <= live_q;
            end
        end
    end
endmodule

// File: tb/tb_invader_formation.sv
// Bench for invader_formation: vector table, hand-built march/clear/bottom sequences,
// and randomized traffic, all checked every cycle against a grid-level reference model.
module tb_invader_formation;
    localparam int unsigned ROWS = 5;
    localparam int unsigned COLS = 11;
    localparam int unsigned N    = ROWS * COLS;
    localparam int unsigned IW   = $clog2(N);
    localparam int CELL_W = 32, CELL_H = 32, RES_H = 640, BOTTOM_Y = 416;
    localparam int START_X = 64, START_Y = 48, STEP_X = 4, STEP_Y = 16;
    localparam int BASE_INTERVAL = 32, MIN_INTERVAL = 2, SPEED_SHIFT = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    invader_formation_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    invader_formation #(
        .ROWS(ROWS), .COLS(COLS), .CELL_W(CELL_W), .CELL_H(CELL_H), .RES_H(RES_H),
        .BOTTOM_Y(BOTTOM_Y), .START_X(START_X), .START_Y(START_Y), .STEP_X(STEP_X),
        .STEP_Y(STEP_Y), .BASE_INTERVAL(BASE_INTERVAL), .MIN_INTERVAL(MIN_INTERVAL),
        .SPEED_SHIFT(SPEED_SHIFT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: grid of live cells plus origin, direction, frame count
    bit g [ROWS][COLS];
    int mx, my, mdir, mcnt, mlive, mhalt, mint;
    logic [N-1:0] p_alive;
    int  p_x, p_y, p_cnt;
    bit  p_move, p_clear, p_bottom;

    typedef struct {
        bit hv;
        int idx;
        bit frame;
        int exp_count;
        int bit_idx;
        bit exp_bit;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] pack_grid();
        logic [N-1:0] v = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (g[r][c]) v = v | (N'(1) << (r * COLS + c));
        return v;
    endfunction

    task automatic model_reset_work();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) g[r][c] = 1'b1;
        mx = START_X; my = START_Y; mdir = 1; mcnt = 0; mlive = N; mhalt = 0;
`ifdef INVADER_SPEEDUP_EN
        mint = MIN_INTERVAL + (N >> SPEED_SHIFT);
`else
        mint = BASE_INTERVAL;
`endif
    endtask

    task automatic model_reset_all();
        model_reset_work();
        p_alive = '1; p_x = START_X; p_y = START_Y; p_cnt = N;
        p_move = 1'b0; p_clear = 1'b0; p_bottom = 1'b0;
    endtask

    task automatic model_step(input bit d, input bit f, input bit hv, input int idx);
        int lc, rc, br, nx, ny, ndir, ncnt, nlive, nhalt, nint;
        bit nmove, nclear, nbottom;
        if (d) begin
            model_reset_work();
            p_move = 1'b0; p_clear = 1'b0; p_bottom = 1'b0;
            return;
        end
        lc = COLS; rc = -1; br = -1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (g[r][c]) begin
                    if (c < lc) lc = c;
                    if (c > rc) rc = c;
                    if (r > br) br = r;
                end
        nx = mx; ny = my; ndir = mdir; ncnt = mcnt; nlive = mlive; nhalt = mhalt; nint = mint;
        nmove = 1'b0; nclear = 1'b0; nbottom = p_bottom;
        if (f) begin
            p_alive = pack_grid(); p_x = mx; p_y = my; p_cnt = mlive;
        end
        if (hv && idx < N && g[idx / COLS][idx % COLS]) begin
            g[idx / COLS][idx % COLS] = 1'b0;
            nlive = mlive - 1;
            if (mlive == 1) begin nclear = 1'b1; nhalt = 1; end
        end
        if (f && mhalt == 0) begin
            ncnt = mcnt + 1;
            if (ncnt >= mint) begin
                ncnt = 0; nmove = 1'b1;
`ifdef INVADER_SPEEDUP_EN
                nint = MIN_INTERVAL + (mlive >> SPEED_SHIFT);
`endif
                if (mdir == 1) begin
                    if (mx + (rc + 1) * CELL_W + STEP_X > RES_H) begin ny = (my + STEP_Y) % 1024; ndir = 0; end
                    else nx = (mx + STEP_X) % 1024;
                end else begin
                    if (mx + lc * CELL_W < STEP_X) begin ny = (my + STEP_Y) % 1024; ndir = 1; end
                    else nx = (mx - STEP_X + 1024) % 1024;
                end
            end
        end
        if (mlive > 0 && my + (br + 1) * CELL_H >= BOTTOM_Y) begin nbottom = 1'b1; nhalt = 1; end
        mx = nx; my = ny; mdir = ndir; mcnt = ncnt; mlive = nlive; mhalt = nhalt; mint = nint;
        p_move = nmove; p_clear = nclear; p_bottom = nbottom;
    endtask

    task automatic check_outputs();
        check("alive",          64'(bus.alive),          64'(p_alive));
        check("form_x",         64'(bus.form_x),         64'(p_x));
        check("form_y",         64'(bus.form_y),         64'(p_y));
        check("alive_count",    64'(bus.alive_count),    64'(p_cnt));
        check("move_pulse",     64'(bus.move_pulse),     64'(p_move));
        check("wave_clear",     64'(bus.wave_clear),     64'(p_clear));
        check("reached_bottom", 64'(bus.reached_bottom), 64'(p_bottom));
    endtask

    // Called at a falling edge: drive, advance model, sample at the next falling edge
    task automatic cycle(input bit d, input bit f, input bit hv, input int idx);
        bus.done = d; bus.frame = f; bus.hit_valid = hv; bus.hit_idx = IW'(idx);
        model_step(d, f, hv, idx);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, mv, guard, idx;
        bit f, hv, d;

        tbl[0] = '{1'b0,  0, 1'b1, 55,  3, 1'b1};
        tbl[1] = '{1'b1,  3, 1'b0, 55,  3, 1'b1};
        tbl[2] = '{1'b0,  0, 1'b1, 54,  3, 1'b0};
        tbl[3] = '{1'b1,  3, 1'b0, 54,  3, 1'b0};
        tbl[4] = '{1'b1, 60, 1'b0, 54,  3, 1'b0};
        tbl[5] = '{1'b0,  0, 1'b1, 54,  3, 1'b0};
        tbl[6] = '{1'b1, 10, 1'b1, 54, 10, 1'b1};
        tbl[7] = '{1'b0,  0, 1'b1, 53, 10, 1'b0};

        rst = 1'b1;
        bus.done = 1'b0; bus.frame = 1'b0; bus.hit_valid = 1'b0; bus.hit_idx = '0;
        model_reset_all();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_outputs();

        repeat (4) cycle(1'b0, 1'b1, 1'b0, 0);
        check("reset_alive", 64'(bus.alive),       64'({N{1'b1}}));
        check("reset_x",     64'(bus.form_x),      64'(64));
        check("reset_y",     64'(bus.form_y),      64'(48));
        check("reset_count", 64'(bus.alive_count), 64'(55));

        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, tbl[i].frame, tbl[i].hv, tbl[i].idx);
            check("tbl_count", 64'(bus.alive_count), 64'(tbl[i].exp_count));
            check("tbl_bit",   64'((bus.alive >> tbl[i].bit_idx) & N'(1)), 64'(tbl[i].exp_bit));
            check("tbl_x",     64'(bus.form_x), 64'(64));
        end

        // Restart, then 33 frames: one move at frame 32, visible at frame 33
        cycle(1'b1, 1'b0, 1'b0, 0);
        pulses = 0;
        for (int k = 0; k < 33; k++) begin
            cycle(1'b0, 1'b1, 1'b0, 0); if (bus.move_pulse) pulses++;
            cycle(1'b0, 1'b0, 1'b0, 0); if (bus.move_pulse) pulses++;
        end
        check("march_pulses", 64'(pulses), 64'(1));
        check("march_x",      64'(bus.form_x), 64'(68));

        // Empty column 10: rightmost live column becomes 9, drop at x = 320
        for (int r = 0; r < ROWS; r++) cycle(1'b0, 1'b0, 1'b1, r * COLS + COLS - 1);
        guard = 0;
        while (bus.form_y == 10'(START_Y) && guard < 6000) begin
            cycle(1'b0, 1'b1, 1'b0, 0); cycle(1'b0, 1'b0, 1'b0, 0); guard++;
        end
        check("drop_in_time", 64'(guard < 6000), 64'(1));
        check("drop_x",       64'(bus.form_x), 64'(320));
        check("drop_y",       64'(bus.form_y), 64'(64));
        guard = 0;
        while (bus.form_x == 10'd320 && guard < 200) begin
            cycle(1'b0, 1'b1, 1'b0, 0); cycle(1'b0, 1'b0, 1'b0, 0); guard++;
        end
        check("flip_x", 64'(bus.form_x), 64'(316));
        check("flip_y", 64'(bus.form_y), 64'(64));

        // Clear the wave: single wave_clear, then no further marching
        cycle(1'b1, 1'b0, 1'b0, 0);
        pulses = 0;
        for (int i = 0; i < N; i++) begin
            cycle(1'b0, 1'b0, 1'b1, i); if (bus.wave_clear) pulses++;
        end
        repeat (3) begin cycle(1'b0, 1'b0, 1'b0, 0); if (bus.wave_clear) pulses++; end
        check("wave_clear_pulses", 64'(pulses), 64'(1));
        mv = 0;
        repeat (40) begin
            cycle(1'b0, 1'b1, 1'b0, 0); if (bus.move_pulse) mv++;
            cycle(1'b0, 1'b0, 1'b0, 0); if (bus.move_pulse) mv++;
        end
        check("halted_moves", 64'(mv), 64'(0));
        check("clear_count",  64'(bus.alive_count), 64'(0));
        check("clear_alive",  64'(bus.alive), 64'(0));
        cycle(1'b1, 1'b0, 1'b0, 0);
        check("done_holds_count", 64'(bus.alive_count), 64'(0));
        cycle(1'b0, 1'b1, 1'b0, 0);
        check("restart_alive", 64'(bus.alive),       64'({N{1'b1}}));
        check("restart_x",     64'(bus.form_x),      64'(64));
        check("restart_y",     64'(bus.form_y),      64'(48));
        check("restart_count", 64'(bus.alive_count), 64'(55));

        // March a full grid down to the bottom limit (y = 256 with row 4 live)
        cycle(1'b1, 1'b0, 1'b0, 0);
        guard = 0;
        while (!bus.reached_bottom && guard < 40000) begin
            cycle(1'b0, 1'b1, 1'b0, 0); guard++;
        end
        check("bottom_in_time", 64'(guard < 40000), 64'(1));
        mv = 0;
        repeat (40) begin cycle(1'b0, 1'b1, 1'b0, 0); if (bus.move_pulse) mv++; end
        check("bottom_sticky", 64'(bus.reached_bottom), 64'(1));
        check("bottom_y",      64'(bus.form_y), 64'(256));
        check("bottom_moves",  64'(mv), 64'(0));
        cycle(1'b1, 1'b0, 1'b0, 0);
        check("bottom_cleared", 64'(bus.reached_bottom), 64'(0));

        // Randomized traffic with occasional restarts
        for (int i = 0; i < 3000; i++) begin
            f   = ($urandom_range(0, 2) == 0);
            hv  = ($urandom_range(0, 15) == 0);
            d   = ($urandom_range(0, 399) == 0);
            idx = int'($urandom_range(0, 63));
            cycle(d, f, hv, idx);
        end
        for (int i = 0; i < 2000; i++) begin
            hv  = ($urandom_range(0, 7) == 0);
            idx = int'($urandom_range(0, 63));
            cycle(1'b0, 1'b1, hv, idx);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
